dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder answering load/store requests issued by the pipeline's MEM stage.
- Replaces the zero-latency data memory with a req/ready handshake.
- The pipeline holds F/D/E/M and bubbles W while `ready` is low.
- Word-organised storage with byte-enable writes, a programmable fixed wait-state count, and an out-of-range error response.

Parameters:
- DEPTH, 1024, number of 32-bit words; byte address range 0 .. DEPTH*4-1.
- AW, 10, word-index width; must equal clog2(DEPTH).
- LATENCY, 2, wait cycles between acceptance and response; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  request valid; requester holds it and all request fields stable until `ready`.
- we  input  1  1 = store, 0 = load; sampled at acceptance.
- addr  input  32  byte address; bits [1:0] ignored; sampled at acceptance.
- be  input  4  byte enables for stores (bit i selects wdata[8i+7:8i]); ignored for loads.
- wdata  input  32  store data; sampled at acceptance.
- busy  output  1  a transaction is in flight (state WAIT or RESP).
- ready  output  1  one-cycle response strobe.
- rdata  output  32  load data; valid only while `ready` = 1.
- err  output  1  qualifies `ready`; the accepted address was out of range.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, wait counter = 0.
  - ready = 0, err = 0, busy = 0, rdata = 0.
  - Latched request registers are cleared.
  - Memory array contents are not reset; loads from unwritten words return unspecified data.
- State IDLE:
  - If req = 1, accept: latch we, addr[AW+1:2], be, wdata, and range flag oor = (addr >= DEPTH*4).
  - Counter is loaded with LATENCY.
  - Next state is WAIT if LATENCY > 0, else RESP.
  - req = 0: stay in IDLE.
- State WAIT:
  - busy = 1; counter decrements each cycle.
  - When counter reaches 1, next state is RESP.
  - Acceptance to ready therefore takes exactly LATENCY+1 cycles.
  - Input changes during WAIT are ignored; the latched copy is used.
- State RESP (one cycle only):
  - ready = 1, busy = 1; next state is always IDLE.
  - Load, in range: rdata = mem[idx] read combinationally from the array in this cycle; err = 0.
  - Store, in range: at the clock edge ending RESP, byte i of mem[idx] is replaced with wdata byte i for each be[i] = 1. rdata = 0, err = 0.
  - Store with be = 0: no memory change; still completes normally.
  - Out of range (oor = 1): err = 1, rdata = 0, memory untouched for both loads and stores.
- Handshake rules:
  - `ready` is a single-cycle pulse. The requester deasserts `req` or presents the next request in the cycle after `ready`.
  - If `req` is still 1 in the IDLE cycle following RESP, it is a new transaction.
  - Back-to-back throughput: one transaction per LATENCY+2 cycles, with a mandatory IDLE bubble.
  - Read-after-write to the same word in consecutive transactions returns the merged new data; the write committed at the RESP edge.
- Reset mid-operation: the transaction is abandoned and no memory write occurs (the write commits only at the RESP edge). Outputs take reset values immediately.
- The counter never wraps; LATENCY = 0 bypasses WAIT entirely.
- No X-propagation on outputs: rdata is driven to 0 whenever ready = 0.

Test Plan:
- LATENCY=2, reset release; store addr 0x0000_0010, be=4'hF, wdata 0xDEAD_BEEF:
  - Acceptance at cycle n; ready=1, err=0 at cycle n+3 only; busy high cycles n+1..n+3.
- Load 0x10 after the previous store:
  - ready at n+3 with rdata 0xDEAD_BEEF; rdata = 0 in all other cycles.
- Partial store 0x10, be=4'b0101, wdata 0x1122_3344, then load 0x10:
  - rdata 0xDE22_BE44.
- Load addr 0x0000_1000 (= DEPTH*4), then store to the same address:
  - Load: ready with err=1, rdata=0.
  - Store: ready with err=1; a subsequent load of word 0 is unchanged.
- LATENCY=0, req held high for 3 back-to-back loads:
  - ready pulses at cycles n+1, n+3, n+5; never two consecutive ready cycles.
- Store 0x20 data 0x0000_00AA accepted, reset pulsed low during WAIT:
  - ready, busy and rdata drop immediately to 0.
  - After release, a load of 0x20 returns the pre-existing contents; 0xAA was not written.

Source files
------------

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// dmem_responder_if : request/response bundle between MEM stage and responder
// Revision 1.0
// ============================================================================
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        busy;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, be, wdata,
    input  busy, ready, rdata, err
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output busy, ready, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : multi-cycle word memory with byte-enable stores, fixed
//                  wait states and out-of-range error response
// Revision 1.0
// ============================================================================
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_WAIT  = 2'd1;
  localparam logic [1:0]  S_RESP  = 2'd2;
  localparam logic [32:0] C_LIMIT = 33'(DEPTH) << 2;
  localparam logic [3:0]  C_LAT   = 4'(LATENCY);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q;
  logic [AW-1:0] idx_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic          oor_q;
  logic [31:0]   mem_q [DEPTH];
  logic          w_accept;
  logic          w_commit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_accept = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          w_accept = 1'b1;
          cnt_d    = C_LAT;
          state_d  = (C_LAT != 4'd0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // <= guards a zero count so the counter can never wrap
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
    end else if (w_accept) begin
      we_q    <= bus.we;
      idx_q   <= bus.addr[AW+1:2];
      be_q    <= bus.be;
      wdata_q <= bus.wdata;
      oor_q   <= ({1'b0, bus.addr} >= C_LIMIT);
    end
  end

  // Stores commit only on the edge that ends RESP, so a reset earlier drops them
  assign w_commit = (state_q == S_RESP) && we_q && !oor_q;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    bus.busy  = (state_q != S_IDLE);
    bus.ready = (state_q == S_RESP);
    bus.err   = (state_q == S_RESP) && oor_q;
    bus.rdata = '0;
    if ((state_q == S_RESP) && !we_q && !oor_q) begin
      bus.rdata = mem_q[idx_q];
    end
  end

endmodule
`default_nettype wire
